// File: rtl/mmu_feeder.sv
// Weight/activation sequencer feeding a weight-stationary SIZE x SIZE systolic array.
// Define MMU_FEEDER_RESULT_TAG_EN to generate result_valid from a delayed issue strobe.
module mmu_feeder_lane #(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] i_din,
  output logic [BIT_WIDTH-1:0] o_dout
);
  logic [BIT_WIDTH-1:0] r_sh [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < DEPTH; d++) r_sh[d] <= '0;
    end else begin
      r_sh[0] <= i_din;
      for (int d = 1; d < DEPTH; d++) r_sh[d] <= r_sh[d-1];
    end
  end

  assign o_dout = r_sh[DEPTH-1];
endmodule

module mmu_feeder #(
  parameter int BIT_WIDTH = 8,
  parameter int SIZE      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_wt_valid,
  output logic                      o_wt_ready,
  input  logic [SIZE*BIT_WIDTH-1:0] i_wt_row,
  input  logic                      i_act_valid,
  output logic                      o_act_ready,
  input  logic [SIZE*BIT_WIDTH-1:0] i_act_vec,
  input  logic                      i_act_last,
  output logic                      o_control,
  output logic [BIT_WIDTH-1:0]      o_wt_arr   [SIZE],
  output logic [BIT_WIDTH-1:0]      o_data_arr [SIZE],
  output logic                      o_issue_valid,
  output logic                      o_result_valid,
  output logic                      o_busy
);
  localparam int CW = $clog2(2*SIZE);
  localparam int IW = $clog2(SIZE);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  state_t                         r_state, w_state_nxt;
  logic [CW-1:0]                  r_cnt, w_cnt_nxt;
  logic [SIZE*BIT_WIDTH-1:0]      r_buf [SIZE];
  logic [SIZE*BIT_WIDTH-1:0]      r_wt_row, w_wt_nxt;
  logic [IW-1:0]                  w_ld_idx;
  logic                           r_control;
  logic                           r_issue_valid;
  logic                           w_act_acc;
  logic [SIZE-1:0][BIT_WIDTH-1:0] w_act_inj;

  assign w_act_acc = i_act_valid && (r_state == STREAM);
  assign w_act_inj = w_act_acc ? i_act_vec : '0;
  assign o_busy    = (r_state != IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wt_nxt    = '0;
    o_wt_ready  = 1'b0;
    o_act_ready = 1'b0;
    // LOAD cycle k presents buf[SIZE-1-k]; the register stage means we fetch one ahead.
    w_ld_idx    = IW'(SIZE-2) - IW'(r_cnt);
    case (r_state)
      IDLE: begin
        o_wt_ready = 1'b1;
        if (i_wt_valid) begin
          if (r_cnt == CW'(SIZE-1)) begin
            w_state_nxt = LOAD;
            w_cnt_nxt   = '0;
            w_wt_nxt    = i_wt_row;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      LOAD: begin
        if (r_cnt == CW'(SIZE-1)) begin
          w_state_nxt = STREAM;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          w_wt_nxt  = r_buf[w_ld_idx];
        end
      end
      STREAM: begin
        o_act_ready = 1'b1;
        if (i_act_valid && i_act_last) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        // 2*SIZE-1 zero cycles flush the deepest lane plus the array's diagonal.
        if (r_cnt == CW'(2*SIZE-2)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_wt_row      <= '0;
      r_control     <= 1'b0;
      r_issue_valid <= 1'b0;
      for (int k = 0; k < SIZE; k++) r_buf[k] <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_wt_row      <= w_wt_nxt;
      r_control     <= (w_state_nxt == LOAD);
      r_issue_valid <= w_act_acc;
      if (r_state == IDLE && i_wt_valid) r_buf[IW'(r_cnt)] <= i_wt_row;
    end
  end

  assign o_control     = r_control;
  assign o_issue_valid = r_issue_valid;

  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    assign o_wt_arr[g] = r_wt_row[g*BIT_WIDTH +: BIT_WIDTH];
    mmu_feeder_lane #(.BIT_WIDTH(BIT_WIDTH), .DEPTH(g+1)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .i_din  (w_act_inj[g]),
      .o_dout (o_data_arr[g])
    );
  end

`ifdef MMU_FEEDER_RESULT_TAG_EN
  logic [SIZE:0] r_vld_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_vld_pipe <= '0;
    else        r_vld_pipe <= {r_vld_pipe[SIZE-1:0], r_issue_valid};
  end

  assign o_result_valid = r_vld_pipe[SIZE];
`else
  assign o_result_valid = 1'b0;
`endif
endmodule

// File: tb/tb_mmu_feeder.sv
// Randomized bench for mmu_feeder against a per-edge timeline model of tiles and vectors.
module tb_mmu_feeder;
  localparam int BW = 8, S = 4, W = S*BW, HN = 8192;

  logic clk = 1'b0, reset = 1'b0;
  logic wt_valid = 1'b0, act_valid = 1'b0, act_last = 1'b0;
  logic [W-1:0] wt_row = '0, act_vec = '0;
  logic wt_ready, act_ready, control, issue_valid, result_valid, busy;
  logic [BW-1:0] wt_arr [S];
  logic [BW-1:0] data_arr [S];

  always #5 clk = ~clk;

  mmu_feeder #(.BIT_WIDTH(BW), .SIZE(S)) dut (
    .clk(clk), .reset(reset),
    .i_wt_valid(wt_valid), .o_wt_ready(wt_ready), .i_wt_row(wt_row),
    .i_act_valid(act_valid), .o_act_ready(act_ready), .i_act_vec(act_vec), .i_act_last(act_last),
    .o_control(control), .o_wt_arr(wt_arr), .o_data_arr(data_arr),
    .o_issue_valid(issue_valid), .o_result_valid(result_valid), .o_busy(busy)
  );

  typedef enum {P_IDLE, P_LOAD, P_STREAM, P_DRAIN} ph_t;

  int n_tests = 0, n_fail = 0, cyc = 0, rst_edge = 0, ctl_cnt = 0;
  bit in_rst = 1'b1;
  bit hv [HN];
  logic [W-1:0] hvec [HN];
  logic [W-1:0] rows [S];
  logic [W-1:0] ld_rows [S];
  int m_rows = 0, m_L = -1, m_f = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  // Tile phase seen in the cycle after edge n: rows collected, SIZE load cycles, stream, drain.
  function automatic ph_t phase(input int n);
    if (m_L < 0 || n < m_L) return P_IDLE;
    if (n < m_L + S)        return P_LOAD;
    if (m_f < 0 || n < m_f) return P_STREAM;
    if (n < m_f + 2*S - 1)  return P_DRAIN;
    return P_IDLE;
  endfunction

  function automatic bit vld_at(input int e);
    if (e <= rst_edge || e < 0) return 1'b0;
    return hv[e];
  endfunction

  function automatic logic [W-1:0] vec_at(input int e);
    if (!vld_at(e)) return '0;
    return hvec[e];
  endfunction

  task automatic check_outputs();
    int n;
    bit ectl;
    ph_t p;
    logic [W-1:0] ew, ed, ow, od, v;
    n = cyc;
    p = phase(n);
    ectl = (m_L >= 0 && n >= m_L && n < m_L + S);
    ew = ectl ? ld_rows[S-1-(n-m_L)] : '0;
    for (int i = 0; i < S; i++) begin
      v = vec_at(n - i);
      ed[i*BW +: BW] = v[i*BW +: BW];
      ow[i*BW +: BW] = wt_arr[i];
      od[i*BW +: BW] = data_arr[i];
    end
    if (control) ctl_cnt++;
    chk("control",     64'(control),     64'(ectl));
    chk("wt_arr",      64'(ow),          64'(ew));
    chk("data_arr",    64'(od),          64'(ed));
    chk("issue_valid", 64'(issue_valid), 64'(vld_at(n)));
`ifdef MMU_FEEDER_RESULT_TAG_EN
    chk("result_valid", 64'(result_valid), 64'(vld_at(n - S - 1)));
`else
    chk("result_valid", 64'(result_valid), 64'(0));
`endif
    chk("wt_ready",  64'(wt_ready),  64'(p == P_IDLE));
    chk("act_ready", 64'(act_ready), 64'(p == P_STREAM));
    chk("busy",      64'(busy),      64'(p != P_IDLE));
  endtask

  task automatic step();
    ph_t p;
    p = phase(cyc);
    hv[cyc+1] = 1'b0;
    if (!in_rst) begin
      if (p == P_IDLE && wt_valid) begin
        rows[m_rows] = wt_row;
        m_rows++;
        if (m_rows == S) begin
          m_L = cyc + 1;
          ld_rows = rows;
        end
      end
      if (p == P_STREAM && act_valid) begin
        hv[cyc+1]   = 1'b1;
        hvec[cyc+1] = act_vec;
        if (act_last) m_f = cyc + 1;
      end
    end
    @(posedge clk);
    cyc++;
    if (in_rst) rst_edge = cyc;
    @(negedge clk);
    check_outputs();
    if (m_f >= 0 && phase(cyc) == P_IDLE) begin
      m_L = -1; m_f = -1; m_rows = 0;
    end
  endtask

  task automatic wait_phase(input ph_t target, input string tag);
    int b;
    b = 0;
    while (phase(cyc) != target && b < 40) begin
      step();
      b++;
    end
    if (b >= 40) chk(tag, 64'(1), 64'(0));
  endtask

  task automatic mid_reset();
    reset = 1'b0;
    in_rst = 1'b1;
    m_L = -1; m_f = -1; m_rows = 0;
    rst_edge = cyc;
    #1;
    chk("rst_control",  64'(control),  64'(0));
    chk("rst_busy",     64'(busy),     64'(0));
    chk("rst_wt_ready", 64'(wt_ready), 64'(1));
  endtask

  initial begin
    int nv, sent, b, f;
    repeat (3) step();
    reset = 1'b1;
    in_rst = 1'b0;
    // activations offered while idle must be ignored
    act_valid = 1'b1; act_vec = 32'h0a0b0c0d;
    repeat (3) step();
    act_valid = 1'b0;

    // directed tile: rows {1..4}..{13..16}, then {1,1,1,1} and {2,3,4,5}
    ctl_cnt = 0;
    for (int k = 0; k < S; k++) begin
      wt_valid = 1'b1;
      for (int j = 0; j < S; j++) wt_row[j*BW +: BW] = 8'(4*k + j + 1);
      step();
    end
    wt_valid = 1'b0;
    wait_phase(P_STREAM, "timeout_load");
    chk("ctl_len", 64'(ctl_cnt), 64'(S));
    act_valid = 1'b1; act_vec = 32'h01010101; act_last = 1'b0; step();
    act_vec = 32'h05040302; act_last = 1'b1; step();
    act_valid = 1'b0; act_last = 1'b0;
    f = cyc;
    b = 0;
    while (!wt_ready && b < 20) begin step(); b++; end
    chk("turnaround", 64'(cyc - f), 64'(2*S - 1));

    // randomized tiles with stalls; first one is a single-vector tile
    for (int t = 0; t < 12; t++) begin
      nv = (t == 0) ? 1 : int'($urandom_range(1, 6));
      b = 0;
      while (m_L < 0 && b < 60) begin
        wt_valid = ($urandom % 4) != 0; wt_row = $urandom;
        act_valid = $urandom % 2; act_vec = $urandom;
        step(); b++;
      end
      if (b >= 60) chk("timeout_rows", 64'(1), 64'(0));
      wt_valid = 1'b0;
      while (phase(cyc) != P_STREAM && b < 80) begin
        act_valid = $urandom % 2; wt_valid = $urandom % 2; act_vec = $urandom;
        step(); b++;
      end
      sent = 0; b = 0;
      while (m_f < 0 && b < 80) begin
        act_valid = ($urandom % 3) != 0; act_vec = $urandom;
        act_last = (sent == nv - 1); wt_valid = $urandom % 2;
        step(); b++;
        if (hv[cyc]) sent++;
      end
      if (b >= 80) chk("timeout_stream", 64'(1), 64'(0));
      wt_valid = 1'b0; act_last = 1'b0;
      b = 0;
      while (busy && b < 20) begin act_valid = $urandom % 2; step(); b++; end
      act_valid = 1'b0;
      wait_phase(P_IDLE, "timeout_drain");
    end

    // reset in the second LOAD cycle discards the tile
    for (int k = 0; k < S; k++) begin wt_valid = 1'b1; wt_row = $urandom; step(); end
    wt_valid = 1'b0;
    step();
    mid_reset();
    repeat (2) step();
    reset = 1'b1;
    in_rst = 1'b0;
    for (int k = 0; k < S-1; k++) begin wt_valid = 1'b1; wt_row = $urandom; step(); end
    wt_valid = 1'b0; act_valid = 1'b1; act_vec = $urandom;
    repeat (6) step();
    chk("partial_busy", 64'(busy), 64'(0));
    act_valid = 1'b0;
    wt_valid = 1'b1; wt_row = $urandom; step();
    wt_valid = 1'b0;
    wait_phase(P_STREAM, "timeout_reload");
    act_valid = 1'b1; act_vec = $urandom; step();
    act_vec = $urandom; act_last = 1'b1; step();
    act_valid = 1'b0; act_last = 1'b0;
    wait_phase(P_IDLE, "timeout_final");
    repeat (S + 3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
